// File: rtl/alu_cmd_pkg.sv
// +--------------------------------------------------------------------+
// | alu_cmd_pkg: opcodes, FSM states and LED helper for alu_cmd_*      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_cmd_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // The processor lights exactly one LED, positioned by the opcode.
  function automatic logic [3:0] led_for_op(input logic [1:0] op);
    return 4'b0001 << op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_golden_model.sv
// +--------------------------------------------------------------------+
// | alu_golden_model: combinational reference of the 4-bit processor   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_golden_model
  import alu_cmd_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] exp_result,
  output logic [3:0] exp_led
);

  always_comb begin
    exp_result = 4'h0;
    case (op)
      OP_ADD:  exp_result = a + b;
      OP_SUB:  exp_result = a - b;
      OP_AND:  exp_result = a & b;
      OP_OR:   exp_result = a | b;
      default: exp_result = 4'h0;
    endcase
    exp_led = led_for_op(op);
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_initiator.sv
// +--------------------------------------------------------------------+
// | alu_cmd_initiator: serialising command front-end for the 4-bit     |
// | processor. Optional self-check: define ALU_CMD_CHECK_EN.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_cmd_initiator
  import alu_cmd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [1:0]       rsp_op,
  output logic             rsp_err,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [3:0]       alu_result,
  input  logic [3:0]       alu_led,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [3:0]       r_rsp_result;
  logic [1:0]       r_rsp_op;
  logic             r_rsp_err;
  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [1:0]       r_alu_ctrl;
  logic             r_busy;
  logic [CNT_W-1:0] r_cmd_count;
  logic             w_err;

`ifdef ALU_CMD_CHECK_EN
  logic [3:0] w_exp_result;
  logic [3:0] w_exp_led;

  alu_golden_model u_golden (
    .op         (r_alu_ctrl),
    .a          (r_alu_a),
    .b          (r_alu_b),
    .exp_result (w_exp_result),
    .exp_led    (w_exp_led)
  );

  assign w_err = (alu_result != w_exp_result) || (alu_led != w_exp_led);
`else
  logic w_unused_led;
  assign w_unused_led = ^alu_led;
  assign w_err        = 1'b0;
`endif

  // cmd_ready resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'h0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 4'h0;
      r_rsp_op     <= 2'd0;
      r_rsp_err    <= 1'b0;
      r_alu_a      <= 4'h0;
      r_alu_b      <= 4'h0;
      r_alu_ctrl   <= 2'd0;
      r_busy       <= 1'b0;
      r_cmd_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_alu_a     <= cmd_a;
            r_alu_b     <= cmd_b;
            r_alu_ctrl  <= cmd_op;
            r_rsp_op    <= cmd_op;
            r_cnt       <= c_settle_load;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rsp_result <= alu_result;
            r_rsp_err    <= w_err;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_count <= r_cmd_count + CNT_W'(1);
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign rsp_err    = r_rsp_err;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;
  assign busy       = r_busy;
  assign cmd_count  = r_cmd_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_initiator.sv
// +--------------------------------------------------------------------+
// | tb_alu_cmd_initiator: directed + random bench for alu_cmd_initiator|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_cmd_initiator;

  localparam int TB_SETTLE = 3;
  localparam int TB_CNT_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = 2'd0;
  logic [3:0]          cmd_a = 4'h0;
  logic [3:0]          cmd_b = 4'h0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [3:0]          rsp_result;
  logic [1:0]          rsp_op;
  logic                rsp_err;
  logic [3:0]          alu_a;
  logic [3:0]          alu_b;
  logic [1:0]          alu_ctrl;
  logic [3:0]          alu_result;
  logic [3:0]          alu_led;
  logic                busy;
  logic [TB_CNT_W-1:0] cmd_count;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cmds = 0;
  bit  corrupt_led = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_initiator #(
    .SETTLE_CYCLES (TB_SETTLE),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_led    (alu_led),
    .busy       (busy),
    .cmd_count  (cmd_count)
  );

  // Reference behaviour of the processor, straight from the opcode table.
  function automatic logic [3:0] ref_result(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
    int r;
    case (op)
      2'd0:    r = (int'(a) + int'(b)) % 16;
      2'd1:    r = (int'(a) - int'(b) + 16) % 16;
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return 4'(r);
  endfunction

  // Processor stub driven by the DUT's operand registers.
  always_comb begin
    alu_result = ref_result(alu_ctrl, alu_a, alu_b);
    alu_led    = corrupt_led ? 4'b0000 : (4'b0001 << alu_ctrl);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
    return 32'(done_cmds % (1 << TB_CNT_W));
  endfunction

  // Issue one command, stall the response for 'hold' cycles, then accept it.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int hold, input bit bad_led, output int acc_cyc);
    int         n;
    logic [3:0] exp_r;
    bit         exp_e;
    exp_r = ref_result(op, a, b);
`ifdef ALU_CMD_CHECK_EN
    exp_e = bad_led;
`else
    exp_e = 1'b0;
`endif
    corrupt_led = bad_led;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    @(negedge clk);
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_ctrl", 32'(alu_ctrl), 32'(op));
    check("busy_settle", 32'(busy), 32'd1);
    check("ready_settle", 32'(cmd_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("rsp_latency", 32'(n - 1), 32'(TB_SETTLE));
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", 32'(rsp_result), 32'(exp_r));
      check("hold_ready", 32'(cmd_ready), 32'd0);
      check("hold_alu_a", 32'(alu_a), 32'(a));
    end
    cmd_valid = 1'b0;
    check("rsp_result", 32'(rsp_result), 32'(exp_r));
    check("rsp_op", 32'(rsp_op), 32'(op));
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    corrupt_led = 1'b0;
    done_cmds++;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
    check("cmd_count", 32'(cmd_count), exp_count());
  endtask

  initial begin
    int  t0, t1, t2;
    bit  saw_valid;
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    run_cmd(2'd0, 4'h9, 4'h8, 0, 1'b0, t0);

    // Back-to-back stream: spacing is settle time plus two cycles.
    run_cmd(2'd1, 4'h3, 4'h5, 0, 1'b0, t0);
    run_cmd(2'd2, 4'hC, 4'hA, 0, 1'b0, t1);
    run_cmd(2'd3, 4'h5, 4'hA, 0, 1'b0, t2);
    check("spacing_1", 32'(t1 - t0), 32'(TB_SETTLE + 2));
    check("spacing_2", 32'(t2 - t1), 32'(TB_SETTLE + 2));

    run_cmd(2'd3, 4'h6, 4'h9, 5, 1'b0, t0);
    run_cmd(2'd3, 4'h1, 4'h2, 0, 1'b1, t0);

    // Reset in the middle of SETTLE drops the command.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 4'h7; cmd_b = 4'h7;
    t0 = 0;
    while (!cmd_ready && t0 < 50) begin @(negedge clk); t0++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    done_cmds = 0;
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp", 32'({rsp_valid, rsp_result, rsp_op, rsp_err}), 32'd0);
    check("mid_rst_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
    check("mid_rst_count", 32'(cmd_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (TB_SETTLE + 3) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("no_rsp_after_rst", 32'(saw_valid), 32'd0);
    run_cmd(2'd0, 4'h4, 4'h3, 1, 1'b0, t0);

    for (int i = 0; i < 16; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
